// File: rtl/dbg_seg_scan_pkg.sv
// Shared constants and types for the debug-bus 7-segment reader.
// Glyphs are active-low, bit 0 = segment a.
package dbg_seg_scan_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int NUM_PAGES  = 8;

    typedef logic [2:0] page_t;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer.
// Emits a one-cycle press pulse when a stable high level is accepted.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Count consecutive samples that differ from the accepted level.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/dbg_seg_scan.sv
// Debug-bus reader: snapshots one 24-bit word per v_f rise and
// scans it as six hex digits on a common-anode display.
module dbg_seg_scan
    import dbg_seg_scan_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_f,
    input  logic        page_btn,
    input  logic [23:0] word0,
    input  logic [23:0] word1,
    input  logic [23:0] word2,
    input  logic [23:0] word3,
    input  logic [23:0] word4,
    input  logic [23:0] word5,
    input  logic [23:0] word6,
    input  logic [23:0] word7,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  an,
    output logic [2:0]  page
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_MAX    = PW'(SCAN_DIV - 1);
    localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

    logic          vf1_q, vf1_d;
    logic          vf2_q, vf2_d;
    logic          vf3_q, vf3_d;
    page_t         page_q, page_d;
    logic          reload_q, reload_d;
    logic [23:0]   snap_q, snap_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    digit_q, digit_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    an_q, an_d;

    logic          press;
    logic          rise;
    logic          tick;
    logic [3:0]    nib;
    logic [23:0]   word_sel;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(page_btn),
        .press  (press)
    );

    // Live word of the currently selected page.
    always_comb begin
        word_sel = '0;
        unique case (page_q)
            3'd0: word_sel = word0;
            3'd1: word_sel = word1;
            3'd2: word_sel = word2;
            3'd3: word_sel = word3;
            3'd4: word_sel = word4;
            3'd5: word_sel = word5;
            3'd6: word_sel = word6;
            3'd7: word_sel = word7;
        endcase
    end

    // Next state: sync, page step, snapshot, scan and output decode.
    always_comb begin
        vf1_d    = v_f;
        vf2_d    = vf1_q;
        vf3_d    = vf2_q;
        rise     = vf2_q & ~vf3_q;
        page_d   = press ? page_q + 3'd1 : page_q;
        reload_d = press;
        // Reload one cycle after a page step; page_q already holds
        // the new index, so a coincident rise also loads the new word.
        snap_d   = (reload_q || rise) ? word_sel : snap_q;
        tick     = (presc_q == PRE_MAX);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        digit_d  = digit_q;
        if (tick) begin
            digit_d = (digit_q == LAST_DIGIT) ? 3'd0 : digit_q + 3'd1;
        end
        nib      = snap_q[{digit_q, 2'b00} +: 4];
        seg_d    = hex_to_seg(nib);
        // Blank the anodes for the first cycle of every digit.
        an_d     = (presc_q == '0) ? 6'h3F : ~(6'd1 << digit_q);
        dp_d     = !((digit_q == 3'd0) && (snap_q != word_sel));
    end

    // All state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vf1_q    <= 1'b0;
            vf2_q    <= 1'b0;
            vf3_q    <= 1'b0;
            page_q   <= '0;
            reload_q <= 1'b0;
            snap_q   <= '0;
            presc_q  <= '0;
            digit_q  <= '0;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            an_q     <= 6'h3F;
        end else begin
            vf1_q    <= vf1_d;
            vf2_q    <= vf2_d;
            vf3_q    <= vf3_d;
            page_q   <= page_d;
            reload_q <= reload_d;
            snap_q   <= snap_d;
            presc_q  <= presc_d;
            digit_q  <= digit_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
        end
    end

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign an   = an_q;
    assign page = page_q;

endmodule

// File: tb/tb_dbg_seg_scan.sv
// Directed bench for dbg_seg_scan with short scan and debounce periods.
// Vector table for digit decode plus hand sequences for timing cases.
module tb_dbg_seg_scan;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v_f = 1'b0;
    logic        page_btn = 1'b0;
    logic [23:0] w [8];
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  an;
    logic [2:0]  page;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [23:0] word;
        int          dig;
        logic [6:0]  seg;
    } vec_t;

    vec_t vecs [8];

    dbg_seg_scan #(
        .SCAN_DIV  (SCAN),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .v_f     (v_f),
        .page_btn(page_btn),
        .word0   (w[0]),
        .word1   (w[1]),
        .word2   (w[2]),
        .word3   (w[3]),
        .word4   (w[4]),
        .word5   (w[5]),
        .word6   (w[6]),
        .word7   (w[7]),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .page    (page)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_an(input logic [5:0] tgt, input string name);
        int k;
        k = 0;
        while (an !== tgt && k < 100) begin
            step(1);
            k++;
        end
        chk(name, {26'd0, an}, {26'd0, tgt});
    endtask

    task automatic wait_lit(input string name);
        int k;
        k = 0;
        while (an === 6'h3F && k < 100) begin
            step(1);
            k++;
        end
        chk(name, {26'd0, an}, 32'h3E);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] exp_an;
        int         q;

        vecs[0] = '{24'h123456, 0, 7'h02};
        vecs[1] = '{24'h123456, 5, 7'h79};
        vecs[2] = '{24'hABCDEF, 0, 7'h0E};
        vecs[3] = '{24'hABCDEF, 3, 7'h46};
        vecs[4] = '{24'h890000, 4, 7'h10};
        vecs[5] = '{24'h890000, 5, 7'h00};
        vecs[6] = '{24'h7A2E00, 2, 7'h06};
        vecs[7] = '{24'h7A2E00, 4, 7'h08};

        for (int i = 0; i < 8; i++) w[i] = 24'($urandom);

        // Reset state
        #1 rst = 1'b0;
        #1;
        chk("rst seg", {25'd0, seg}, 32'h7F);
        chk("rst an", {26'd0, an}, 32'h3F);
        chk("rst dp", {31'd0, dp}, 32'h1);
        chk("rst page", {29'd0, page}, 32'h0);
        step(3);
        rst = 1'b1;
        wait_lit("first lit an");
        chk("first seg", {25'd0, seg}, 32'h40);

        // Capture latency: value present two edges after v_f is seen
        w[0] = 24'h111111;
        v_f  = 1'b1;
        step(2);
        w[0] = 24'h123456;
        step(1);
        w[0] = 24'h654321;
        v_f  = 1'b0;
        wait_an(6'b111110, "lat an d0");
        chk("lat seg d0", {25'd0, seg}, 32'h02);
        chk("lat dp moved", {31'd0, dp}, 32'h0);
        wait_an(6'b011111, "lat an d5");
        chk("lat seg d5", {25'd0, seg}, 32'h79);
        chk("lat dp d5", {31'd0, dp}, 32'h1);
        w[0] = 24'h123456;
        wait_an(6'b111110, "lat an d0b");
        chk("lat dp still", {31'd0, dp}, 32'h1);

        // Digit decode vectors
        for (int i = 0; i < 8; i++) begin
            w[0] = vecs[i].word;
            v_f  = 1'b1;
            step(4);
            v_f  = 1'b0;
            step(2);
            wait_an(~(6'd1 << vecs[i].dig), "vec an");
            chk($sformatf("vec%0d seg", i), {25'd0, seg},
                {25'd0, vecs[i].seg});
            chk($sformatf("vec%0d dp", i), {31'd0, dp}, 32'h1);
        end

        // Scan order and ghost blanking
        wait_an(6'b011111, "scan sync d5");
        wait_an(6'b111110, "scan sync d0");
        for (int i = 0; i < 25; i++) begin
            q = (i + 1) % 24;
            exp_an = (q % 4 == 0) ? 6'h3F : ~(6'd1 << (q / 4));
            chk($sformatf("scan an %0d", i), {26'd0, an},
                {26'd0, exp_an});
            step(1);
        end

        // Debounce: short glitches rejected
        for (int i = 0; i < 3; i++) begin
            page_btn = 1'b1;
            step(5);
            page_btn = 1'b0;
            step(12);
        end
        chk("glitch page", {29'd0, page}, 32'h0);

        // Eight accepted presses wrap the page back to 0
        for (int p = 0; p < 8; p++) begin
            page_btn = 1'b1;
            step(14);
            page_btn = 1'b0;
            step(14);
            chk($sformatf("press %0d page", p), {29'd0, page},
                32'((p + 1) % 8));
        end

        // Press pulse and v_f rise in the same cycle
        w[0] = 24'h111111;
        w[1] = 24'hABCDEF;
        page_btn = 1'b1;
        step(8);
        v_f = 1'b1;
        step(6);
        page_btn = 1'b0;
        v_f = 1'b0;
        step(14);
        chk("coll page", {29'd0, page}, 32'h1);
        wait_an(6'b111110, "coll an d0");
        chk("coll seg d0", {25'd0, seg}, 32'h0E);
        chk("coll dp d0", {31'd0, dp}, 32'h1);
        wait_an(6'b011111, "coll an d5");
        chk("coll seg d5", {25'd0, seg}, 32'h08);

        // Live word moves: dp low on digit 0 only
        w[1] = 24'hABCDE0;
        for (int i = 0; i < 24; i++) begin
            if (an !== 6'h3F) begin
                chk("moved dp", {31'd0, dp},
                    (an === 6'b111110) ? 32'h0 : 32'h1);
            end
            step(1);
        end
        wait_an(6'b111110, "moved an d0");
        chk("moved seg d0", {25'd0, seg}, 32'h0E);

        // Async reset mid-scan (digit 3) and mid-debounce
        wait_an(6'b111101, "mid sync d1");
        wait_an(6'b111011, "mid sync d2");
        page_btn = 1'b1;
        step(5);
        chk("mid an d3", {26'd0, an}, 32'h37);
        #2 rst = 1'b0;
        #1;
        chk("mid rst seg", {25'd0, seg}, 32'h7F);
        chk("mid rst an", {26'd0, an}, 32'h3F);
        chk("mid rst dp", {31'd0, dp}, 32'h1);
        chk("mid rst page", {29'd0, page}, 32'h0);
        page_btn = 1'b0;
        step(2);
        rst = 1'b1;
        wait_lit("post rst lit");
        chk("post rst seg", {25'd0, seg}, 32'h40);
        step(20);
        chk("post rst page", {29'd0, page}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbg_seg_scan.md
Name: dbg_seg_scan

Overview:
Reader side of the processor's 24-bit debug output bus (zero flag, control word, instruction halves, ALU result, PC, two register reads). Freezes one selected debug word on each rising edge of the divided step clock v_f. Shows that word as 6 hex digits on a multiplexed common-anode 7-segment display. A debounced push-button cycles through the 8 debug words.

Parameters:
SCAN_DIV, 50000, clk cycles per digit dwell (min 2)
DEB_CYCLES, 500000, clk cycles the synced button must be stable to be accepted (min 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
v_f  input  1  divided step clock from frequency divider, asynchronous to scan logic
page_btn  input  1  raw push-button, active-high
word0..word7  input  24 each  debug words: out_zero, control_signal, instr_lower, instr_upper, alu, program_counter, register_1, register_2
seg  output  7  segments a..g, active-low, seg[0]=a
dp  output  1  decimal point, active-low
an  output  6  digit anodes, active-low, an[0]=least-significant nibble
page  output  3  currently selected word index

Behaviour:
- Reset (rst low, async) values: seg=7'h7F, dp=1, an=6'h3F, page=0, snapshot=0, digit index=0, prescaler=0, debounce state cleared.
- v_f sync: 3-flop chain s1->s2->s3. rise = s2 & ~s3. snapshot <= word[page] on the edge where rise=1. A v_f high at clk edge N appears in snapshot after edge N+2, i.e. 3rd edge counting N.
- Page debounce: page_btn passes a 2-flop sync. A counter restarts on any change of the synced level. The accepted level updates only after DEB_CYCLES consecutive equal samples. A 0->1 transition of the accepted level gives a 1-cycle press pulse.
- Press pulse: page <= page+1 mod 8 (7 wraps to 0). On the next cycle the snapshot reloads from the new page's word, so the display never shows the old page's value under the new page index.
- Simultaneous rise and page-reload in one cycle: page-reload wins, loading word[new page]. No lost or double update.
- Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and digit advances 0..5, with 5 wrapping to 0.
- Outputs are registered, one clk after the internal state:
  - an = one-hot-low of digit, e.g. digit 2 -> 6'b111011.
  - seg = hex decode of snapshot[4*digit+:4], full 0-F glyph table.
- Ghost blanking: in the first output cycle after each digit change, an=6'h3F.
- dp is low only while digit=0 and snapshot != word[page] (live value has moved since capture). Otherwise dp is high.
- Reset mid-scan or mid-debounce immediately forces all reset values. The first digit shown after release is digit 0.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - NUM_DIGITS=6, NUM_PAGES=8
  - the 16-entry hex-to-7seg active-low glyph constant table (0->7'h40, 1->7'h79, 6->7'h02, 8->7'h00, F->7'h0E)
  - the page index typedef (3-bit)
- One sub-module is natural: btn_debounce (parameter DEB_CYCLES; ports clk, rst, btn_raw, press). Scan, sync and snapshot logic stay in the top.

Test Plan:
1. Reset: hold rst low with random inputs, pulse mid-run -> seg=7F, an=3F, dp=1, page=0 within same cycle as rst fall. After release, first lit an=111110, seg=40 (snapshot 0).
2. Capture latency (SCAN_DIV=4): word0=24'h123456, raise v_f -> snapshot=123456 after 3rd clk edge. Then:
   - digit 0: seg=02 ('6')
   - digit 5: seg=79 ('1')
   - dp stays high while word0 is unchanged.
3. Scan order/blanking (SCAN_DIV=4): observe 24 cycles -> an sequence 111110..011111, then back to 111110. Each digit's first cycle is blanked to 3F, followed by 3 lit cycles.
4. Debounce (DEB_CYCLES=8): 5-cycle glitches on page_btn -> page stays 0. Stable high for 10 cycles -> page=1. Eight stable presses from page 0 -> page returns to 0 after the 8th.
5. Page/v_f collision: assert press pulse and v_f rise in the same cycle with word1=ABCDEF, word0=111111 -> snapshot=ABCDEF, page=1. Afterwards change word1 -> dp low only on digit 0.
6. Async reset mid-debounce and mid-scan (digit 3): assert rst -> all outputs reset immediately. After release the partially counted press is discarded and page=0.
